coin_payer: RTL and testbench

//  Buyer-side driver for the newsstand coin interface: given a wallet (nickel/dime

---
 rtl/coin_payer.sv | 196 +++++++++++++++++++
 tb/tb_coin_payer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/coin_payer.sv
// Buyer-side coin driver for the newsstand interface: spends a captured wallet one coin
// per cycle until 15c is paid, then waits for the newspaper and checks the change.
module coin_payer #(
  parameter int CNT_W    = 4,
  parameter int COIN_GAP = 0,
  parameter int TIMEOUT  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pref_dime,
  input  logic [CNT_W-1:0] nickels_avail,
  input  logic [CNT_W-1:0] dimes_avail,
  input  logic             newspaper,
  input  logic             change,
  output logic [2:0]       coin,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] nickels_spent,
  output logic [CNT_W-1:0] dimes_spent,
  output logic [CNT_W-1:0] papers_bought
);

  localparam int GW = (COIN_GAP > 1) ? $clog2(COIN_GAP) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [GW-1:0]      GAP_LAST  = GW'((COIN_GAP > 0) ? COIN_GAP - 1 : 0);
  localparam logic [TW-1:0]      WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W+1:0]   MIN_FUNDS = (CNT_W + 2)'(3);
  localparam logic [CNT_W-1:0]   ONE       = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, INSERT, GAP, WAIT, FIN} state_t;
  typedef enum logic [1:0] {ST_OK, ST_NOFUNDS, ST_TIMEOUT, ST_CHANGE_ERR} status_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] nw, nw_n, dw, dw_n;
  logic [4:0]       credit, credit_n;
  logic             pref_q, pref_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic [TW-1:0]    wcnt, wcnt_n;
  logic [2:0]       coin_n;
  logic             busy_n, done_n;
  logic [1:0]       status_n;
  logic [CNT_W-1:0] nspent_n, dspent_n, papers_n;

  logic             ins, use_dime, p_src;
  logic [CNT_W-1:0] n_src, d_src, ns_src, ds_src;
  logic [4:0]       c_src;
  logic [CNT_W+1:0] funds;

  assign funds = {2'b00, nickels_avail} + {1'b0, dimes_avail, 1'b0};

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      nw            <= '0;
      dw            <= '0;
      credit        <= '0;
      pref_q        <= 1'b0;
      gcnt          <= '0;
      wcnt          <= '0;
      coin          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      status        <= ST_OK;
      nickels_spent <= '0;
      dimes_spent   <= '0;
      papers_bought <= '0;
    end else begin
      state         <= state_n;
      nw            <= nw_n;
      dw            <= dw_n;
      credit        <= credit_n;
      pref_q        <= pref_n;
      gcnt          <= gcnt_n;
      wcnt          <= wcnt_n;
      coin          <= coin_n;
      busy          <= busy_n;
      done          <= done_n;
      status        <= status_n;
      nickels_spent <= nspent_n;
      dimes_spent   <= dspent_n;
      papers_bought <= papers_n;
    end
  end

  // Next-state logic; outputs are precomputed here so each one leaves a register.
  always_comb begin
    state_n  = state;
    nw_n     = nw;
    dw_n     = dw;
    credit_n = credit;
    pref_n   = pref_q;
    gcnt_n   = '0;
    wcnt_n   = '0;
    coin_n   = '0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    status_n = status;
    nspent_n = nickels_spent;
    dspent_n = dimes_spent;
    papers_n = papers_bought;
    ins      = 1'b0;
    use_dime = 1'b0;
    n_src    = nw;
    d_src    = dw;
    c_src    = credit;
    ns_src   = nickels_spent;
    ds_src   = dimes_spent;
    p_src    = pref_q;

    case (state)
      IDLE: begin
        if (start) begin
          if (funds < MIN_FUNDS) begin
            state_n  = FIN;
            done_n   = 1'b1;
            status_n = ST_NOFUNDS;
          end else begin
            state_n = INSERT;
            busy_n  = 1'b1;
            ins     = 1'b1;
            n_src   = nickels_avail;
            d_src   = dimes_avail;
            c_src   = '0;
            ns_src  = '0;
            ds_src  = '0;
            p_src   = pref_dime;
          end
        end
      end
      INSERT: begin
        busy_n = 1'b1;
        if (credit >= 5'd15) begin
          state_n = WAIT;
        end else if (COIN_GAP > 0) begin
          state_n = GAP;
        end else begin
          ins = 1'b1;
        end
      end
      GAP: begin
        busy_n = 1'b1;
        if (gcnt == GAP_LAST) begin
          state_n = INSERT;
          ins     = 1'b1;
        end else begin
          gcnt_n = gcnt + GW'(1);
        end
      end
      WAIT: begin
        if (newspaper) begin
          state_n = FIN;
          done_n  = 1'b1;
          // Exactly 5c must come back on an overpayment of 20c, nothing otherwise.
          if (change == (credit == 5'd20)) begin
            status_n = ST_OK;
            if (papers_bought != '1) papers_n = papers_bought + ONE;
          end else begin
            status_n = ST_CHANGE_ERR;
          end
        end else if (wcnt == WAIT_LAST) begin
          state_n  = FIN;
          done_n   = 1'b1;
          status_n = ST_TIMEOUT;
        end else begin
          busy_n = 1'b1;
          wcnt_n = wcnt + TW'(1);
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (ins) begin
      use_dime = p_src ? (d_src != '0) : (n_src == '0);
      pref_n   = p_src;
      nw_n     = n_src;
      dw_n     = d_src;
      nspent_n = ns_src;
      dspent_n = ds_src;
      if (use_dime) begin
        coin_n   = 3'd2;
        dw_n     = d_src - ONE;
        dspent_n = ds_src + ONE;
        credit_n = c_src + 5'd10;
      end else begin
        coin_n   = 3'd1;
        nw_n     = n_src - ONE;
        nspent_n = ns_src + ONE;
        credit_n = c_src + 5'd5;
      end
    end
  end

endmodule

// File: tb/tb_coin_payer.sv
// Randomised bench for coin_payer: two instances (COIN_GAP 0 and 2) share stimulus and
// are checked every cycle against a purchase-level schedule computed from the wallet rules.
module tb_coin_payer;

  localparam int CW = 4;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pref_dime = 1'b0;
  logic [CW-1:0] nav = '0;
  logic [CW-1:0] dav = '0;
  logic          np [2];
  logic          ch [2];
  logic [2:0]    coin [2];
  logic          busy [2];
  logic          done [2];
  logic [1:0]    status [2];
  logic [CW-1:0] nsp [2];
  logic [CW-1:0] dsp [2];
  logic [CW-1:0] papers [2];

  always #5 clock = ~clock;

  coin_payer #(.CNT_W(CW), .COIN_GAP(0), .TIMEOUT(TO)) u0 (
    .clock(clock), .reset(reset), .start(start), .pref_dime(pref_dime),
    .nickels_avail(nav), .dimes_avail(dav), .newspaper(np[0]), .change(ch[0]),
    .coin(coin[0]), .busy(busy[0]), .done(done[0]), .status(status[0]),
    .nickels_spent(nsp[0]), .dimes_spent(dsp[0]), .papers_bought(papers[0]));

  coin_payer #(.CNT_W(CW), .COIN_GAP(2), .TIMEOUT(TO)) u1 (
    .clock(clock), .reset(reset), .start(start), .pref_dime(pref_dime),
    .nickels_avail(nav), .dimes_avail(dav), .newspaper(np[1]), .change(ch[1]),
    .coin(coin[1]), .busy(busy[1]), .done(done[1]), .status(status[1]),
    .nickels_spent(nsp[1]), .dimes_spent(dsp[1]), .papers_bought(papers[1]));

  typedef struct {
    int coin; int busy; int done; int status; int nsp; int dsp; int papers; int chk;
  } exp_t;

  exp_t     q0[$], q1[$];
  bit [1:0] s0[$], s1[$];
  int       pm [2];
  int       held_status [2];
  int       held_papers [2];
  int       total = 0;
  int       bad = 0;

  task automatic checkOutput(input string name, input int inst, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s u%0d: got %0d want %0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  function automatic bit [1:0] noise();
    return 2'($urandom_range(0, 3));
  endfunction

  task automatic pushExp(input int inst, input exp_t e, input bit [1:0] s);
    if (inst == 0) begin q0.push_back(e); s0.push_back(s); end
    else           begin q1.push_back(e); s1.push_back(s); end
  endtask

  // One purchase as a cycle schedule starting the cycle after start: expected outputs
  // plus the machine's {newspaper,change}; resp = cycles after the last coin until paper.
  task automatic plan(input int inst, input int g, input int n, input int d, input bit pref,
                      input int resp, input bit good);
    exp_t e;
    int credit, nn, dd, ns, ds, st, nwait;
    int coins[$];
    e = '{default: 0};
    if (n + 2 * d < 3) begin
      e.done = 1; e.status = 1; e.papers = pm[inst];
      pushExp(inst, e, noise());
      return;
    end
    credit = 0; nn = n; dd = d; ns = 0; ds = 0;
    while (credit < 15) begin
      if (pref ? (dd > 0) : (nn == 0)) begin coins.push_back(2); dd--; ds++; credit += 10; end
      else                             begin coins.push_back(1); nn--; ns++; credit += 5;  end
    end
    e.busy = 1;
    foreach (coins[j]) begin
      e.coin = coins[j];
      pushExp(inst, e, noise());
      e.coin = 0;
      if (j < coins.size() - 1) repeat (g) pushExp(inst, e, noise());
    end
    nwait = (resp <= TO) ? resp : TO;
    for (int w = 1; w <= nwait; w++)
      pushExp(inst, e, (w == resp) ? {1'b1, (good ? (credit == 20) : (credit != 20))}
                                   : {1'b0, 1'($urandom_range(0, 1))});
    if (resp > TO) st = 2;
    else           st = good ? 0 : 3;
    if (st == 0 && pm[inst] < 15) pm[inst]++;
    e.busy = 0; e.done = 1; e.status = st; e.nsp = ns; e.dsp = ds; e.papers = pm[inst]; e.chk = 1;
    pushExp(inst, e, noise());
  endtask

  task automatic driveMachine();
    if (s0.size() > 0) {np[0], ch[0]} = s0.pop_front(); else {np[0], ch[0]} = noise();
    if (s1.size() > 0) {np[1], ch[1]} = s1.pop_front(); else {np[1], ch[1]} = noise();
  endtask

  task automatic applyStimulus(input int n, input int d, input bit pref, input int resp,
                               input bit good);
    @(negedge clock);
    start = 1'b1; nav = CW'(n); dav = CW'(d); pref_dime = pref;
    plan(0, 0, n, d, pref, resp, good);
    plan(1, 2, n, d, pref, resp, good);
    while (s0.size() > 0 || s1.size() > 0) begin
      @(negedge clock);
      // Both instances are mid-purchase here, so any start or wallet value must be ignored.
      if (s0.size() > 0 && s1.size() > 0) begin
        start = 1'($urandom_range(0, 1)); nav = CW'($urandom); dav = CW'($urandom);
      end else begin
        start = 1'b0;
      end
      driveMachine();
    end
    @(negedge clock);
    start = 1'b0;
    driveMachine();
  endtask

  task automatic resetMidPurchase();
    @(negedge clock);
    start = 1'b1; nav = CW'(3); dav = '0; pref_dime = 1'b0;
    plan(0, 0, 3, 0, 1'b0, 1, 1'b1);
    plan(1, 2, 3, 0, 1'b0, 1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      start = 1'b0;
      driveMachine();
    end
    // u1 is on its second coin and u0 is seeing its newspaper: both must abort silently.
    reset = 1'b1;
    q0.delete(); q1.delete(); s0.delete(); s1.delete();
    pm = '{0, 0}; held_status = '{0, 0}; held_papers = '{0, 0};
    @(negedge clock);
    reset = 1'b0;
    driveMachine();
  endtask

  task automatic checkCycle(input int i);
    exp_t e;
    bit   idle;
    e = '{default: 0};
    idle = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (!idle) e = (i == 0) ? q0.pop_front() : q1.pop_front();
    checkOutput("coin", i, int'(coin[i]), e.coin);
    checkOutput("busy", i, int'(busy[i]), e.busy);
    checkOutput("done", i, int'(done[i]), e.done);
    if (e.done != 0) begin
      held_status[i] = e.status;
      held_papers[i] = e.papers;
    end
    if (e.done != 0 || idle) begin
      checkOutput("status", i, int'(status[i]), held_status[i]);
      checkOutput("papers_bought", i, int'(papers[i]), held_papers[i]);
    end
    if (e.chk != 0) begin
      checkOutput("nickels_spent", i, int'(nsp[i]), e.nsp);
      checkOutput("dimes_spent", i, int'(dsp[i]), e.dsp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    for (int i = 0; i < 2; i++) checkCycle(i);
  end

  task automatic checkLiteral(input int st, input int ns, input int ds, input int pb);
    for (int i = 0; i < 2; i++) begin
      checkOutput("lit_status", i, int'(status[i]), st);
      if (ns >= 0) checkOutput("lit_nickels_spent", i, int'(nsp[i]), ns);
      if (ds >= 0) checkOutput("lit_dimes_spent", i, int'(dsp[i]), ds);
      checkOutput("lit_papers", i, int'(papers[i]), pb);
    end
  endtask

  initial begin
    np[0] = 1'b0; np[1] = 1'b0; ch[0] = 1'b0; ch[1] = 1'b0;
    pm = '{0, 0}; held_status = '{0, 0}; held_papers = '{0, 0};
    repeat (3) @(negedge clock);
    reset = 1'b0;
    $display("[TB] directed purchases");
    applyStimulus(3, 2, 1'b1, 1, 1'b1);
    checkLiteral(0, 0, 2, 1);
    applyStimulus(3, 0, 1'b0, 1, 1'b1);
    checkLiteral(0, 3, 0, 2);
    applyStimulus(1, 1, 1'b0, 1, 1'b1);
    checkLiteral(0, 1, 1, 3);
    applyStimulus(1, 0, 1'b0, 1, 1'b1);
    checkLiteral(1, -1, -1, 3);
    applyStimulus(2, 2, 1'b1, TO + 1, 1'b1);
    checkLiteral(2, 0, 2, 3);
    applyStimulus(0, 2, 1'b1, 1, 1'b0);
    checkLiteral(3, 0, 2, 3);
    $display("[TB] reset during a purchase");
    resetMidPurchase();
    checkLiteral(0, 0, 0, 0);
    applyStimulus(3, 0, 1'b0, 2, 1'b1);
    checkLiteral(0, 3, 0, 1);
    $display("[TB] random wallets");
    repeat (40)
      applyStimulus($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                    $urandom_range(1, TO + 1), $urandom_range(0, 3) != 0);
    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
